insn_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/insn_fetch.sv | 115 +++++++++++
 tb/tb_insn_fetch.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state, word width and the
// prefetch FIFO entry carrying an instruction together with its PC.
package fetch_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, insn} entries with flush; the head is presented combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited memory requests, buffers
// responses in a prefetch FIFO and discards in-flight responses after a redirect.
module insn_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [WORD_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [WORD_W-1:0] imem_rsp_data,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [WORD_W-1:0] insn,
  output logic [WORD_W-1:0] insn_pc,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  out_q, out_d, drop_q, drop_d, fifo_count;
  logic [CNT_W:0]    credit_sum;
  logic              run_q;
  logic              fifo_empty, unused_full;
  logic              req_fire, rsp_push;
  fetch_entry_t      push_entry, head_entry;

  // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
  assign credit_sum     = {1'b0, fifo_count} + {1'b0, out_q};
  // run_q keeps the request low until the first edge after reset release.
  assign imem_req_valid = run_q && (state_q == FETCH) && !redirect &&
                          (credit_sum < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_push       = imem_rsp_valid && !redirect && (state_q == FETCH);
  assign push_entry     = '{pc: rsp_pc_q, insn: imem_rsp_data};

  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    if (redirect) begin
      // Everything still in flight after this edge is stale.
      drop_d   = out_d;
      state_d  = (out_d != '0) ? DRAIN : FETCH;
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd1;
      end
      if (rsp_push) begin
        rsp_pc_d = rsp_pc_q + 32'd1;
      end
      if (state_q == DRAIN) begin
        if (drop_q == '0) begin
          state_d = FETCH;
        end else if (imem_rsp_valid) begin
          drop_d = drop_q - CNT_W'(1);
          if (drop_q == CNT_W'(1)) begin
            state_d = FETCH;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      run_q    <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rsp_push),
    .push_data(push_entry),
    .pop      (insn_ready),
    .flush    (redirect),
    .head     (head_entry),
    .count    (fifo_count),
    .full     (unused_full),
    .empty    (fifo_empty)
  );

  assign insn_valid = !fifo_empty;
  assign insn       = head_entry.insn;
  assign insn_pc    = head_entry.pc;

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: in-order latency memory model, occupancy/stream scoreboard
// and directed plus randomized scenarios.
module tb_insn_fetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  bit mem_rand = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t pend[$];

  insn_fetch #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .insn_valid    (insn_valid),
    .insn_ready    (insn_ready),
    .insn          (insn),
    .insn_pc       (insn_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In-order memory: each accepted address returns after its latency, one per cycle.
  task automatic mem_model();
    logic        acc, rsp;
    logic [31:0] a;
    int          lat;
    mreq_t       r;
    forever begin
      @(negedge clk);
      acc = imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      rsp = imem_rsp_valid;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        pend.delete();
      end else begin
        if (rsp && pend.size() > 0) r = pend.pop_front();
        if (acc) begin
          lat    = mem_rand ? int'($urandom_range(4, 1)) : mem_lat;
          r.addr = a;
          r.due  = cyc + lat - 1;
          pend.push_back(r);
        end
      end
      #1;
      if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memfn(pend[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  endtask

  // Reference: in-flight, buffered and stale counts; expected request and insn PCs.
  task automatic scoreboard();
    int          m_out, m_occ, m_stale;
    logic [31:0] exp_pc, exp_req, prev_addr;
    logic        prev_hold, acc, rsp, pop;
    m_out = 0; m_occ = 0; m_stale = 0;
    exp_pc = RESET_PC; exp_req = RESET_PC; prev_addr = '0; prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_out = 0; m_occ = 0; m_stale = 0;
        exp_pc = RESET_PC; exp_req = RESET_PC; prev_hold = 1'b0;
      end else begin
        acc = imem_req_valid && imem_req_ready;
        rsp = imem_rsp_valid;
        pop = insn_valid && insn_ready;
        n_checks++;
        if (insn_valid !== (m_occ > 0)) begin
          n_fail++;
          $display("FAIL sb_insn_valid: got %b expected %b (t=%0t)", insn_valid, m_occ > 0, $time);
        end
        if (imem_req_valid) begin
          n_checks++;
          if (m_out + m_occ >= int'(DEPTH) || m_stale != 0) begin
            n_fail++;
            $display("FAIL sb_credit: req_valid=1 with out=%0d occ=%0d stale=%0d, required none",
                     m_out, m_occ, m_stale);
          end
        end
        if (prev_hold && !redirect) begin
          n_checks++;
          if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
            n_fail++;
            $display("FAIL sb_req_hold: got valid=%b addr=%h expected valid=1 addr=%h",
                     imem_req_valid, imem_req_addr, prev_addr);
          end
        end
        if (acc) begin
          n_checks++;
          if (imem_req_addr !== exp_req) begin
            n_fail++;
            $display("FAIL sb_req_addr: got %h expected %h", imem_req_addr, exp_req);
          end
          exp_req = exp_req + 32'd1;
        end
        if (!redirect && pop) begin
          n_checks++;
          if (insn_pc !== exp_pc || insn !== memfn(exp_pc)) begin
            n_fail++;
            $display("FAIL sb_insn: got pc=%h insn=%h expected pc=%h insn=%h",
                     insn_pc, insn, exp_pc, memfn(exp_pc));
          end
          exp_pc = exp_pc + 32'd1;
        end
        if (redirect) begin
          m_stale = m_out + int'(acc) - int'(rsp);
          m_occ   = 0;
          exp_pc  = redirect_pc;
          exp_req = redirect_pc;
        end else begin
          if (rsp) begin
            if (m_stale > 0) m_stale--;
            else m_occ++;
          end
          if (pop) m_occ--;
        end
        m_out     = m_out + int'(acc) - int'(rsp);
        prev_hold = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
      end
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect       = 1'b0;
    insn_ready     = 1'b0;
    imem_req_ready = 1'b0;
    mem_rand       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks += 5;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h expected %h", imem_req_addr, RESET_PC); end
    if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_insn_valid: got %b expected 0", insn_valid); end
    if (insn !== 32'h0) begin n_fail++; $display("FAIL reset_insn: got %h expected 0", insn); end
    if (insn_pc !== 32'h0) begin n_fail++; $display("FAIL reset_insn_pc: got %h expected 0", insn_pc); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: got valid=%b addr=%h expected valid=1 addr=%h",
               imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int first_acc, first_v, pops;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; insn_ready = 1'b1;
    first_acc = -1; first_v = -1; pops = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (first_acc < 0 && imem_req_valid && imem_req_ready) first_acc = i;
      if (first_v < 0 && insn_valid) first_v = i;
      if (insn_valid) pops++;
      tick();
    end
    n_checks += 2;
    if (first_acc < 0 || first_v - first_acc != 2) begin
      n_fail++;
      $display("FAIL stream_latency: got %0d cycles expected 2", first_v - first_acc);
    end
    if (first_v < 0 || pops != 24 - first_v) begin
      n_fail++;
      $display("FAIL stream_throughput: got %0d pops expected %0d", pops, 24 - first_v);
    end
  endtask

  task automatic test_full();
    int  accs;
    bit  found;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; insn_ready = 1'b0;
    accs = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) accs++;
      tick();
    end
    @(negedge clk);
    n_checks += 3;
    if (accs != int'(DEPTH)) begin n_fail++; $display("FAIL full_req_count: got %0d expected %0d", accs, DEPTH); end
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_req_valid: got %b expected 0", imem_req_valid); end
    if (insn_valid !== 1'b1 || insn_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL full_head: got valid=%b pc=%h expected valid=1 pc=%h", insn_valid, insn_pc, RESET_PC);
    end
    tick();
    insn_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        found = 1'b1;
        n_checks++;
        if (imem_req_addr !== RESET_PC + 32'd4) begin
          n_fail++;
          $display("FAIL full_resume_addr: got %h expected %h", imem_req_addr, RESET_PC + 32'd4);
        end
      end
      tick();
    end
    if (!found) begin
      n_checks++; n_fail++;
      $display("FAIL full_resume: got no request in 10 cycles expected one");
    end
  endtask

  task automatic test_hold();
    int          n, accs;
    logic [31:0] exp_addr;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; insn_ready = 1'b1;
    n = int'($urandom_range(7, 3));
    accs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) accs++;
      tick();
    end
    imem_req_ready = 1'b0;
    exp_addr = RESET_PC + 32'(accs);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got valid=%b addr=%h expected valid=1 addr=%h",
                 i, imem_req_valid, imem_req_addr, exp_addr);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_redirect_drain();
    int  accs, stale;
    bit  prev_rsp, found;
    do_reset();
    mem_lat = 3; imem_req_ready = 1'b1; insn_ready = 1'b1;
    accs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) accs++;
      if (accs == 2) break;
      tick();
    end
    tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL drain_withdraw: got %b expected 0", imem_req_valid); end
    tick();
    redirect = 1'b0;
    stale = 0; prev_rsp = 1'b0; found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_checks++;
        if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL drain_flush: got %b expected 0", insn_valid); end
      end
      if (imem_req_valid) begin
        found = 1'b1;
        n_checks++;
        if (stale != 2 || !prev_rsp || imem_req_addr !== 32'h40) begin
          n_fail++;
          $display("FAIL drain_restart: got stale=%0d prev_rsp=%b addr=%h expected 2 1 00000040",
                   stale, prev_rsp, imem_req_addr);
        end
      end
      prev_rsp = imem_rsp_valid;
      if (imem_rsp_valid) stale++;
      tick();
    end
    if (!found) begin n_checks++; n_fail++; $display("FAIL drain_timeout: got no request expected one"); end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (insn_valid) begin
        found = 1'b1;
        n_checks++;
        if (insn_pc !== 32'h40 || insn !== memfn(32'h40)) begin
          n_fail++;
          $display("FAIL drain_first_insn: got pc=%h insn=%h expected pc=00000040 insn=%h",
                   insn_pc, insn, memfn(32'h40));
        end
      end
      tick();
    end
    if (!found) begin n_checks++; n_fail++; $display("FAIL drain_insn_timeout: got none expected insn"); end
  endtask

  task automatic test_redirect_collide();
    bit found;
    do_reset();
    mem_lat = 2; imem_req_ready = 1'b1; insn_ready = 1'b1;
    repeat (8) tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_checks++;
        if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL collide_flush: got %b expected 0", insn_valid); end
      end
      if (insn_valid) begin
        found = 1'b1;
        n_checks++;
        if (insn_pc !== 32'h100) begin
          n_fail++;
          $display("FAIL collide_first_pc: got %h expected 00000100", insn_pc);
        end
      end
      tick();
    end
    if (!found) begin n_checks++; n_fail++; $display("FAIL collide_timeout: got none expected insn"); end
  endtask

  task automatic test_wrap();
    logic [31:0] req_a [2];
    logic [31:0] pop_a [2];
    int          nr, np;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; insn_ready = 1'b1;
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    nr = 0; np = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && nr < 2) begin req_a[nr] = imem_req_addr; nr++; end
      if (insn_valid && insn_ready && np < 2) begin pop_a[np] = insn_pc; np++; end
      tick();
    end
    n_checks += 2;
    if (nr != 2 || req_a[0] !== 32'hFFFF_FFFF || req_a[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_req: got n=%0d %h %h expected ffffffff 00000000", nr, req_a[0], req_a[1]);
    end
    if (np != 2 || pop_a[0] !== 32'hFFFF_FFFF || pop_a[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_insn_pc: got n=%0d %h %h expected ffffffff 00000000", np, pop_a[0], pop_a[1]);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req_valid: got %b expected 0", imem_req_valid); end
    if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL midrst_req_addr: got %h expected %h", imem_req_addr, RESET_PC); end
    if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_insn_valid: got %b expected 0", insn_valid); end
    if (insn !== 32'h0) begin n_fail++; $display("FAIL midrst_insn: got %h expected 0", insn); end
    if (insn_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_insn_pc: got %h expected 0", insn_pc); end
  endtask

  task automatic test_random();
    int pops;
    do_reset();
    mem_rand = 1'b1;
    pops = 0;
    for (int i = 0; i < 800; i++) begin
      imem_req_ready = ($urandom % 4) != 0;
      insn_ready     = ($urandom % 3) != 0;
      if (($urandom % 32) == 0) begin
        redirect    = 1'b1;
        redirect_pc = (i % 2 == 0) ? $urandom : 32'hFFFF_FFFD;
      end else begin
        redirect = 1'b0;
      end
      @(negedge clk);
      if (insn_valid && insn_ready && !redirect) pops++;
      tick();
    end
    redirect = 1'b0;
    mem_rand = 1'b0;
    n_checks++;
    if (pops <= 100) begin
      n_fail++;
      $display("FAIL random_progress: got %0d pops expected more than 100", pops);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    insn_ready     = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    fork
      mem_model();
      scoreboard();
    join_none
    test_reset();
    test_stream();
    test_full();
    test_hold();
    test_redirect_drain();
    test_redirect_collide();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
